fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_queue.sv | 52 +++++
 rtl/fetch_stage.sv | 68 ++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO holding fetched {pc, inst} entries; head is read from storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head_entry
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents are only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[tail] <= push_entry;
  end

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_entry = mem[head];

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection and a small decode-side queue.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  // Handshake: an entry transfers on a clock edge where out_valid && out_ready;
  // out_valid never depends on out_ready and the presented entry is held
  // unchanged until it transfers (or a redirect/reset discards it).

  logic [31:0]  pc_q;
  logic [31:0]  pc_next;
  logic         push;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign imem_pc    = pc_q;
  assign pop        = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full queue keeps streaming.
  assign push       = !redirect_valid && (!q_full || pop);
  assign push_entry = '{pc: pc_q, inst: imem_inst};

  always_comb begin
    pc_next = pc_q;
    if (redirect_valid) pc_next = align_pc(redirect_pc);
    else if (push)      pc_next = pc_q + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_next;
  end

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .full      (q_full),
    .empty     (q_empty),
    .head_entry(head_entry)
  );

  assign out_valid = !q_empty;
  assign out_pc    = head_entry.pc;
  assign out_inst  = head_entry.inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected {pc, inst} entries.
module tb_fetch_stage;

  localparam logic [31:0] RP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int total = 0;
  int bad   = 0;
  bit sb_on = 1'b0;
  logic [63:0] exp_q[$];

  fetch_stage #(
    .RESET_PC   (RP),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_pc       (imem_pc),
    .imem_inst     (imem_inst),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  // Clock / instruction memory model
  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_inst = imem_word(imem_pc);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] entry(input logic [31:0] pc);
    return {pc, imem_word(pc)};
  endfunction

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(entry(start + 32'(4 * i)));
  endtask

  // Called just after a negedge with inputs set; scores the transfer, then advances one cycle.
  task automatic cycle();
    logic [63:0] e;
    if (sb_on && !rst && out_valid && out_ready) begin
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_entry", {out_pc, out_inst}, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic sb_close(input string tag);
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    sb_on = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    cycles(2);
    check("rst_imem_pc", 64'(imem_pc), 64'(RP));
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(dut.u_queue.count), 64'd0);
    rst = 1'b0;

    // Stall after reset: queue fills to 2, head and PC hold
    out_ready = 1'b0;
    cycle();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_pc", 64'(out_pc), 64'(RP));
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_pc", {out_pc, out_inst}, entry(RP));
    end
    check("stall_count", 64'(dut.u_queue.count), 64'd2);
    check("stall_imem_pc", 64'(imem_pc), 64'(RP + 32'h8));

    // Release: in-order delivery, then full-queue streaming at one entry per cycle
    out_ready = 1'b1;
    sb_on = 1'b1;
    expect_run(RP, 9);
    for (int i = 0; i < 9; i++) begin
      check("stream_valid", 64'(out_valid), 64'd1);
      cycle();
    end
    check("stream_count", 64'(dut.u_queue.count), 64'd2);
    sb_close("stream_drained");

    // Fresh reset with decode always ready
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb_on = 1'b1;
    expect_run(RP, 3);
    cycles(4);
    sb_close("ready_drained");

    // Redirect while queue holds two entries; target is word aligned
    out_ready = 1'b0;
    cycles(2);
    check("pre_redir_count", 64'(dut.u_queue.count), 64'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    cycle();
    check("redir_valid", 64'(out_valid), 64'd0);
    check("redir_imem_pc", 64'(imem_pc), 64'h200);
    redirect_valid = 1'b0;
    cycle();
    check("redir_head", {out_pc, out_inst}, entry(32'h200));

    // Redirect with simultaneous pop, then PC wrap past the top of memory
    out_ready = 1'b1;
    sb_on = 1'b1;
    exp_q.push_back(entry(32'h200));
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    expect_run(32'hFFFF_FFF8, 4);
    cycles(5);
    sb_close("wrap_drained");

    // Reset and redirect together mid-stream: reset wins
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0400;
    cycle();
    check("rstredir_pc", 64'(imem_pc), 64'(RP));
    check("rstredir_valid", 64'(out_valid), 64'd0);
    check("rstredir_count", 64'(dut.u_queue.count), 64'd0);
    rst = 1'b0;
    redirect_valid = 1'b0;
    sb_on = 1'b1;
    expect_run(RP, 3);
    cycles(4);
    sb_close("rstredir_drained");

    // Random backpressure: order and contents must be preserved
    sb_on = 1'b1;
    expect_run(RP + 32'hC, 64);
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    check("rand_consumed", 64'(exp_q.size() < 64), 64'd1);
    exp_q.delete();
    sb_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
